// File: rtl/config_pkg.sv
// Global sizing for the operand-read datapath: data width, register count and index width.
package config_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;

  // One-hot mask for a register index, used for scoreboard set/clear.
  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] idx);
    logic [NREGS-1:0] mask;
    mask      = {NREGS{1'b0}};
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/instruction_pkg.sv
// Instruction-side types: the operand bundle carried from operand read into execute.
package instruction_pkg;

  typedef struct packed {
    logic [config_pkg::XLEN-1:0]       rs1_data;
    logic [config_pkg::XLEN-1:0]       rs2_data;
    logic [config_pkg::REG_ADDR_W-1:0] rd;
    logic                              rd_we;
    logic [config_pkg::XLEN-1:0]       tag;
  } operand_bundle_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational read ports, one clocked write port.
// Entry 0 always reads as zero and silently drops writes.
module regfile_2r1w #(
  parameter int XLEN   = config_pkg::XLEN,
  parameter int NREGS  = config_pkg::NREGS,
  parameter int ADDR_W = config_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  output logic [XLEN-1:0]   rd1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [XLEN-1:0]   rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [XLEN-1:0]   wd
);

  logic [XLEN-1:0] mem_r [NREGS];

  // Write port; reset clears every entry and overrides a concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_r[i] <= {XLEN{1'b0}};
      end
    end else if (we && (wa != {ADDR_W{1'b0}})) begin
      mem_r[wa] <= wd;
    end
  end

  // Read ports with x0 forced to zero.
  always_comb begin
    rd1 = {XLEN{1'b0}};
    rd2 = {XLEN{1'b0}};
    if (ra1 != {ADDR_W{1'b0}}) begin
      rd1 = mem_r[ra1];
    end else begin
      rd1 = {XLEN{1'b0}};
    end
    if (ra2 != {ADDR_W{1'b0}}) begin
      rd2 = mem_r[ra2];
    end else begin
      rd2 = {XLEN{1'b0}};
    end
  end

endmodule

// File: rtl/operand_read_stage.sv
// Operand read stage: register-file read, busy-bit scoreboard and one-entry output register.
// Optional macro OPERAND_BYPASS_EN forwards a same-cycle write-back into the accepted operands.
module operand_read_stage
  import instruction_pkg::*;
#(
  parameter int XLEN  = config_pkg::XLEN,
  parameter int NREGS = config_pkg::NREGS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              id_valid,
  output logic                              id_ready,
  input  logic [config_pkg::REG_ADDR_W-1:0] id_rs1,
  input  logic [config_pkg::REG_ADDR_W-1:0] id_rs2,
  input  logic [config_pkg::REG_ADDR_W-1:0] id_rd,
  input  logic                              id_rd_we,
  input  logic [XLEN-1:0]                   id_tag,
  input  logic                              wb_we,
  input  logic [config_pkg::REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]                   wb_data,
  input  logic                              flush,
  output logic                              ex_valid,
  input  logic                              ex_ready,
  output logic [XLEN-1:0]                   ex_rs1_data,
  output logic [XLEN-1:0]                   ex_rs2_data,
  output logic [config_pkg::REG_ADDR_W-1:0] ex_rd,
  output logic                              ex_rd_we,
  output logic [XLEN-1:0]                   ex_tag,
  output logic [NREGS-1:0]                  busy_mask
);

  localparam int AW = config_pkg::REG_ADDR_W;

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_next_s;
  logic [NREGS-1:0] busy_chk_s;
  logic [NREGS-1:0] wb_clr_s;
  logic [NREGS-1:0] flush_clr_s;
  logic [NREGS-1:0] acc_set_s;
  logic             ex_valid_r;
  operand_bundle_t  out_r;
  operand_bundle_t  bundle_s;
  logic [XLEN-1:0]  rf_rs1_s;
  logic [XLEN-1:0]  rf_rs2_s;
  logic [XLEN-1:0]  rs1_val_s;
  logic [XLEN-1:0]  rs2_val_s;
  logic             wb_hit_s;
  logic             hazard_s;
  logic             id_ready_s;
  logic             accept_s;

  regfile_2r1w #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .ADDR_W (AW)
  ) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (id_rs1),
    .rd1 (rf_rs1_s),
    .ra2 (id_rs2),
    .rd2 (rf_rs2_s),
    .we  (wb_we),
    .wa  (wb_rd),
    .wd  (wb_data)
  );

  // Scoreboard clear sources: write-back and a squashed held instruction.
  always_comb begin
    wb_hit_s    = wb_we && (wb_rd != {AW{1'b0}});
    wb_clr_s    = {NREGS{1'b0}};
    flush_clr_s = {NREGS{1'b0}};
    if (wb_hit_s) begin
      wb_clr_s = config_pkg::reg_onehot(wb_rd);
    end else begin
      wb_clr_s = {NREGS{1'b0}};
    end
    if (flush && ex_valid_r && out_r.rd_we && (out_r.rd != {AW{1'b0}})) begin
      flush_clr_s = config_pkg::reg_onehot(out_r.rd);
    end else begin
      flush_clr_s = {NREGS{1'b0}};
    end
  end

  // Hazard check and operand selection, with optional same-cycle write-back forwarding.
  always_comb begin
    busy_chk_s = busy_r;
    rs1_val_s  = rf_rs1_s;
    rs2_val_s  = rf_rs2_s;
`ifdef OPERAND_BYPASS_EN
    busy_chk_s = busy_r & ~wb_clr_s;
    if (wb_hit_s && (wb_rd == id_rs1)) begin
      rs1_val_s = wb_data;
    end else begin
      rs1_val_s = rf_rs1_s;
    end
    if (wb_hit_s && (wb_rd == id_rs2)) begin
      rs2_val_s = wb_data;
    end else begin
      rs2_val_s = rf_rs2_s;
    end
`else
    busy_chk_s = busy_r;
`endif
    hazard_s   = busy_chk_s[id_rs1] || busy_chk_s[id_rs2] || (id_rd_we && busy_chk_s[id_rd]);
    id_ready_s = (!ex_valid_r || ex_ready) && !hazard_s && !flush && !rst;
    accept_s   = id_valid && id_ready_s;
  end

  // Next scoreboard value; clears apply first so a same-edge set wins.
  always_comb begin
    acc_set_s = {NREGS{1'b0}};
    if (accept_s && id_rd_we && (id_rd != {AW{1'b0}})) begin
      acc_set_s = config_pkg::reg_onehot(id_rd);
    end else begin
      acc_set_s = {NREGS{1'b0}};
    end
    busy_next_s    = (busy_r & ~wb_clr_s & ~flush_clr_s) | acc_set_s;
    busy_next_s[0] = 1'b0;
  end

  // Bundle captured into the output register on accept.
  always_comb begin
    bundle_s          = '0;
    bundle_s.rs1_data = rs1_val_s;
    bundle_s.rs2_data = rs2_val_s;
    bundle_s.rd       = id_rd;
    bundle_s.rd_we    = id_rd_we;
    bundle_s.tag      = id_tag;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= {NREGS{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  // Output register: flush squashes, accept loads, a bare transfer empties, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_r <= 1'b0;
      out_r      <= '0;
    end else if (flush) begin
      ex_valid_r <= 1'b0;
    end else if (accept_s) begin
      ex_valid_r <= 1'b1;
      out_r      <= bundle_s;
    end else if (ex_ready) begin
      ex_valid_r <= 1'b0;
    end
  end

  assign id_ready    = id_ready_s;
  assign ex_valid    = ex_valid_r;
  assign ex_rs1_data = out_r.rs1_data;
  assign ex_rs2_data = out_r.rs2_data;
  assign ex_rd       = out_r.rd;
  assign ex_rd_we    = out_r.rd_we;
  assign ex_tag      = out_r.tag;
  assign busy_mask   = busy_r;

endmodule

// File: tb/tb_operand_read_stage.sv
// Self-checking bench for operand_read_stage: directed scenarios plus a randomized run
// against an array-based reference model. Honours OPERAND_BYPASS_EN when defined.
module tb_operand_read_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rd_we, wb_we, flush, ex_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic [31:0] id_tag, wb_data;
  logic        id_ready, ex_valid, ex_rd_we;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_tag, busy_mask;
  logic [4:0]  ex_rd;

  int compared   = 0;
  int mismatched = 0;

`ifdef OPERAND_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  operand_read_stage dut (
    .clk (clk), .rst (rst),
    .id_valid (id_valid), .id_ready (id_ready),
    .id_rs1 (id_rs1), .id_rs2 (id_rs2), .id_rd (id_rd), .id_rd_we (id_rd_we), .id_tag (id_tag),
    .wb_we (wb_we), .wb_rd (wb_rd), .wb_data (wb_data),
    .flush (flush),
    .ex_valid (ex_valid), .ex_ready (ex_ready),
    .ex_rs1_data (ex_rs1_data), .ex_rs2_data (ex_rs2_data),
    .ex_rd (ex_rd), .ex_rd_we (ex_rd_we), .ex_tag (ex_tag),
    .busy_mask (busy_mask)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1; registered outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rd_we = 1'b0; wb_we = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; wb_rd = 5'd0;
    id_tag = 32'd0; wb_data = 32'd0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rdwe, input logic [31:0] tag);
    id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rd_we = rdwe; id_tag = tag;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    issue(5'd3, 5'd4, 5'd5, 1'b1, 32'h55);
    tick(); tick();
    compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("FAIL reset.ex_valid got %0h want 0", ex_valid); end
    compared++; if (busy_mask !== 32'h0) begin mismatched++; $display("FAIL reset.busy_mask got %h want 0", busy_mask); end
    compared++; if (id_ready !== 1'b0) begin mismatched++; $display("FAIL reset.id_ready got %0h want 0", id_ready); end
    compared++; if (ex_tag !== 32'h0 || ex_rs1_data !== 32'h0 || ex_rd !== 5'd0)
      begin mismatched++; $display("FAIL reset.payload got tag=%h rs1=%h rd=%0d want 0", ex_tag, ex_rs1_data, ex_rd); end
    rst = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_wb_read();
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    tick();
    wb_we = 1'b0;
    issue(5'd5, 5'd0, 5'd1, 1'b0, 32'h100);
    #1;
    compared++; if (id_ready !== 1'b1) begin mismatched++; $display("FAIL wb_read.id_ready got %0h want 1", id_ready); end
    tick();
    id_valid = 1'b0;
    compared++; if (ex_valid !== 1'b1) begin mismatched++; $display("FAIL wb_read.ex_valid got %0h want 1", ex_valid); end
    compared++; if (ex_rs1_data !== 32'h1234) begin mismatched++; $display("FAIL wb_read.rs1 got %h want 00001234", ex_rs1_data); end
    compared++; if (ex_rs2_data !== 32'h0) begin mismatched++; $display("FAIL wb_read.rs2 got %h want 0", ex_rs2_data); end
    compared++; if (ex_tag !== 32'h100) begin mismatched++; $display("FAIL wb_read.tag got %h want 100", ex_tag); end
    tick();
    compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("FAIL wb_read.drain got %0h want 0", ex_valid); end
  endtask

  task automatic test_raw_hazard();
    issue(5'd0, 5'd0, 5'd7, 1'b1, 32'h200);
    tick();
    issue(5'd7, 5'd0, 5'd0, 1'b0, 32'h204);
    compared++; if (busy_mask[7] !== 1'b1) begin mismatched++; $display("FAIL raw.busy7_set got %0h want 1", busy_mask[7]); end
    #1;
    compared++; if (id_ready !== 1'b0) begin mismatched++; $display("FAIL raw.stall got %0h want 0", id_ready); end
    tick();
    compared++; if (busy_mask[7] !== 1'b1 || ex_valid !== 1'b0)
      begin mismatched++; $display("FAIL raw.stall_hold got busy7=%0h ex_valid=%0h want 1/0", busy_mask[7], ex_valid); end
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hAA;
    #1;
`ifdef OPERAND_BYPASS_EN
    compared++; if (id_ready !== 1'b1) begin mismatched++; $display("FAIL raw.wb_ready got %0h want 1", id_ready); end
`else
    compared++; if (id_ready !== 1'b0) begin mismatched++; $display("FAIL raw.wb_ready got %0h want 0", id_ready); end
`endif
    tick();
    wb_we = 1'b0;
    compared++; if (busy_mask[7] !== 1'b0) begin mismatched++; $display("FAIL raw.busy7_clr got %0h want 0", busy_mask[7]); end
`ifndef OPERAND_BYPASS_EN
    compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("FAIL raw.not_yet got %0h want 0", ex_valid); end
    #1;
    compared++; if (id_ready !== 1'b1) begin mismatched++; $display("FAIL raw.ready_after got %0h want 1", id_ready); end
    tick();
`endif
    id_valid = 1'b0;
    compared++; if (ex_valid !== 1'b1 || ex_rs1_data !== 32'hAA || ex_tag !== 32'h204)
      begin mismatched++; $display("FAIL raw.dep got v=%0h rs1=%h tag=%h want 1/aa/204", ex_valid, ex_rs1_data, ex_tag); end
    tick();
  endtask

  task automatic test_set_wins();
    issue(5'd0, 5'd0, 5'd7, 1'b1, 32'h300);
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hBB;
    tick();
    id_valid = 1'b0;
    wb_we = 1'b0;
    compared++; if (busy_mask[7] !== 1'b1) begin mismatched++; $display("FAIL set_wins.busy7 got %0h want 1", busy_mask[7]); end
    wb_we = 1'b1;
    tick();
    wb_we = 1'b0;
    compared++; if (busy_mask !== 32'h0) begin mismatched++; $display("FAIL set_wins.clear got %h want 0", busy_mask); end
  endtask

  task automatic test_backpressure();
    ex_ready = 1'b0;
    issue(5'd5, 5'd0, 5'd3, 1'b0, 32'hA0);
    tick();
    issue(5'd0, 5'd0, 5'd4, 1'b0, 32'hB0);
    for (int i = 0; i < 3; i++) begin
      #1;
      compared++; if (id_ready !== 1'b0) begin mismatched++; $display("FAIL bp.id_ready[%0d] got %0h want 0", i, id_ready); end
      tick();
      compared++; if (ex_valid !== 1'b1 || ex_tag !== 32'hA0 || ex_rs1_data !== 32'h1234 || ex_rd !== 5'd3)
        begin mismatched++; $display("FAIL bp.hold[%0d] got v=%0h tag=%h rs1=%h rd=%0d want 1/a0/1234/3", i, ex_valid, ex_tag, ex_rs1_data, ex_rd); end
    end
    ex_ready = 1'b1;
    #1;
    compared++; if (id_ready !== 1'b1) begin mismatched++; $display("FAIL bp.release got %0h want 1", id_ready); end
    tick();
    id_valid = 1'b0;
    compared++; if (ex_valid !== 1'b1 || ex_tag !== 32'hB0)
      begin mismatched++; $display("FAIL bp.next got v=%0h tag=%h want 1/b0", ex_valid, ex_tag); end
    tick();
    compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("FAIL bp.drain got %0h want 0", ex_valid); end
  endtask

  task automatic test_x0();
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
    tick();
    wb_we = 1'b0;
    issue(5'd0, 5'd0, 5'd0, 1'b1, 32'hC0);
    tick();
    id_valid = 1'b0;
    compared++; if (ex_valid !== 1'b1 || ex_rs1_data !== 32'h0 || ex_rs2_data !== 32'h0)
      begin mismatched++; $display("FAIL x0.read got v=%0h rs1=%h rs2=%h want 1/0/0", ex_valid, ex_rs1_data, ex_rs2_data); end
    compared++; if (busy_mask !== 32'h0) begin mismatched++; $display("FAIL x0.busy got %h want 0", busy_mask); end
    tick();
  endtask

  task automatic test_flush();
    ex_ready = 1'b0;
    issue(5'd0, 5'd0, 5'd9, 1'b1, 32'hD0);
    tick();
    compared++; if (busy_mask[9] !== 1'b1 || ex_valid !== 1'b1)
      begin mismatched++; $display("FAIL flush.held got busy9=%0h v=%0h want 1/1", busy_mask[9], ex_valid); end
    issue(5'd0, 5'd0, 5'd0, 1'b0, 32'hD4);
    flush = 1'b1;
    #1;
    compared++; if (id_ready !== 1'b0) begin mismatched++; $display("FAIL flush.block got %0h want 0", id_ready); end
    tick();
    flush = 1'b0;
    compared++; if (ex_valid !== 1'b0 || busy_mask[9] !== 1'b0)
      begin mismatched++; $display("FAIL flush.squash got v=%0h busy9=%0h want 0/0", ex_valid, busy_mask[9]); end
    issue(5'd9, 5'd0, 5'd0, 1'b0, 32'hD8);
    ex_ready = 1'b1;
    #1;
    compared++; if (id_ready !== 1'b1) begin mismatched++; $display("FAIL flush.no_stall got %0h want 1", id_ready); end
    tick();
    id_valid = 1'b0;
    compared++; if (ex_valid !== 1'b1 || ex_tag !== 32'hD8)
      begin mismatched++; $display("FAIL flush.after got v=%0h tag=%h want 1/d8", ex_valid, ex_tag); end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    compared++; if (ex_valid !== 1'b0 || busy_mask !== 32'h0)
      begin mismatched++; $display("FAIL flush.idle got v=%0h busy=%h want 0/0", ex_valid, busy_mask); end
  endtask

  task automatic test_reset_mid();
    wb_we = 1'b1; wb_rd = 5'd8; wb_data = 32'h55;
    tick();
    wb_we = 1'b0;
    issue(5'd0, 5'd0, 5'd8, 1'b1, 32'hE0);
    tick();
    issue(5'd0, 5'd0, 5'd9, 1'b1, 32'hE4);
    tick();
    id_valid = 1'b0; ex_ready = 1'b0;
    compared++; if (busy_mask !== 32'h300 || ex_valid !== 1'b1)
      begin mismatched++; $display("FAIL rstmid.pre got busy=%h v=%0h want 300/1", busy_mask, ex_valid); end
    rst = 1'b1;
    wb_we = 1'b1; wb_rd = 5'd8; wb_data = 32'h77;
    tick();
    rst = 1'b0; wb_we = 1'b0;
    compared++; if (busy_mask !== 32'h0 || ex_valid !== 1'b0)
      begin mismatched++; $display("FAIL rstmid.post got busy=%h v=%0h want 0/0", busy_mask, ex_valid); end
    issue(5'd8, 5'd0, 5'd0, 1'b0, 32'hE8);
    ex_ready = 1'b1;
    tick();
    id_valid = 1'b0;
    compared++; if (ex_valid !== 1'b1 || ex_rs1_data !== 32'h0)
      begin mismatched++; $display("FAIL rstmid.x8 got v=%0h rs1=%h want 1/0", ex_valid, ex_rs1_data); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] mem [32];
    logic        bsy [32];
    logic        m_v, m_rdwe;
    logic [31:0] m_rs1, m_rs2, m_tag, exp_mask, opa, opb;
    logic [4:0]  m_rd;
    logic        wb_hit, haz, exp_ready, acc;
    logic        b1, b2, b3;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 0; r < 32; r++) begin mem[r] = 32'd0; bsy[r] = 1'b0; end
    m_v = 1'b0; m_rdwe = 1'b0; m_rs1 = 32'd0; m_rs2 = 32'd0; m_tag = 32'd0; m_rd = 5'd0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      id_valid = 1'($urandom_range(0, 1));
      id_rs1   = 5'($urandom_range(0, 7));
      id_rs2   = 5'($urandom_range(0, 7));
      id_rd    = 5'($urandom_range(0, 7));
      id_rd_we = 1'($urandom_range(0, 1));
      id_tag   = $urandom;
      wb_we    = ($urandom_range(0, 2) == 0);
      wb_rd    = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      flush    = ($urandom_range(0, 15) == 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      #1;
      wb_hit = wb_we && (wb_rd != 5'd0);
      b1 = (id_rs1 != 5'd0) && bsy[id_rs1] && !(BYP && wb_hit && wb_rd == id_rs1);
      b2 = (id_rs2 != 5'd0) && bsy[id_rs2] && !(BYP && wb_hit && wb_rd == id_rs2);
      b3 = (id_rd  != 5'd0) && bsy[id_rd]  && !(BYP && wb_hit && wb_rd == id_rd);
      haz = b1 || b2 || (id_rd_we && b3);
      exp_ready = (!m_v || ex_ready) && !haz && !flush;
      acc = id_valid && exp_ready;
      compared++; if (id_ready !== exp_ready)
        begin mismatched++; $display("FAIL rand.id_ready cyc=%0d got %0h want %0h", cyc, id_ready, exp_ready); end
      opa = (id_rs1 == 5'd0) ? 32'd0 : ((BYP && wb_hit && wb_rd == id_rs1) ? wb_data : mem[id_rs1]);
      opb = (id_rs2 == 5'd0) ? 32'd0 : ((BYP && wb_hit && wb_rd == id_rs2) ? wb_data : mem[id_rs2]);
      tick();
      if (flush) begin
        if (m_v && m_rdwe && m_rd != 5'd0) bsy[m_rd] = 1'b0;
        m_v = 1'b0;
      end
      if (wb_hit) begin mem[wb_rd] = wb_data; bsy[wb_rd] = 1'b0; end
      if (acc) begin
        m_v = 1'b1; m_rs1 = opa; m_rs2 = opb; m_rd = id_rd; m_rdwe = id_rd_we; m_tag = id_tag;
        if (id_rd_we && id_rd != 5'd0) bsy[id_rd] = 1'b1;
      end else if (!flush && ex_ready) begin
        m_v = 1'b0;
      end
      exp_mask = 32'd0;
      for (int r = 0; r < 32; r++) exp_mask[r] = bsy[r];
      compared++; if (ex_valid !== m_v)
        begin mismatched++; $display("FAIL rand.ex_valid cyc=%0d got %0h want %0h", cyc, ex_valid, m_v); end
      compared++; if (busy_mask !== exp_mask)
        begin mismatched++; $display("FAIL rand.busy_mask cyc=%0d got %h want %h", cyc, busy_mask, exp_mask); end
      if (m_v) begin
        compared++;
        if (ex_rs1_data !== m_rs1 || ex_rs2_data !== m_rs2 || ex_rd !== m_rd || ex_rd_we !== m_rdwe || ex_tag !== m_tag)
          begin mismatched++; $display("FAIL rand.payload cyc=%0d got %h/%h/%0d/%0h/%h want %h/%h/%0d/%0h/%h", cyc,
            ex_rs1_data, ex_rs2_data, ex_rd, ex_rd_we, ex_tag, m_rs1, m_rs2, m_rd, m_rdwe, m_tag); end
      end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_wb_read();
    test_raw_hazard();
    test_set_wins();
    test_backpressure();
    test_x0();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/operand_read_stage.md
OPERAND_READ_STAGE -- requirements
Module: operand_read_stage

Interface
REQ-001 Parameter XLEN, 32, data width of registers and operands.
REQ-002 Parameter NREGS, 32, number of architectural registers; x0 is hardwired to zero.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 id_valid  input  1  decoded instruction presented.
REQ-006 id_ready  output  1  stage accepts the instruction this cycle.
REQ-007 id_rs1, id_rs2, id_rd  input  5 each  source and destination register indices.
REQ-008 id_rd_we  input  1  instruction writes id_rd.
REQ-009 id_tag  input  XLEN  opaque payload (PC), passed through unchanged.
REQ-010 wb_we, wb_rd, wb_data  input  1/5/XLEN  write port driven by the write-back stage.
REQ-011 flush  input  1  squash the instruction held in the output register.
REQ-012 ex_valid, ex_ready  output/input  1/1  handshake toward execute.
REQ-013 ex_rs1_data, ex_rs2_data  output  XLEN  operand values.
REQ-014 ex_rd, ex_rd_we, ex_tag  output  5/1/XLEN  registered copies of id_rd, id_rd_we and id_tag.
REQ-015 busy_mask  output  NREGS  scoreboard contents; bit 0 is always 0.

Function
REQ-016 Accept condition: id_valid && id_ready; transfer to execute: ex_valid && ex_ready.
REQ-017 id_ready = (!ex_valid || ex_ready) && !hazard && !flush.
REQ-018 hazard = busy[rs1] || busy[rs2] || (id_rd_we && busy[rd]), where index 0 is never busy.
REQ-019 On accept, the output register loads operands, rd, rd_we and tag, and ex_valid is 1 on the next cycle (1-cycle latency).
REQ-020 On accept with id_rd_we=1 and id_rd!=0, busy[id_rd] is set on the next edge.
REQ-021 When wb_we=1 and wb_rd!=0, the register file writes wb_data and clears busy[wb_rd] on the same edge; writes to x0 are ignored.
REQ-022 If set and clear of the same busy bit occur on the same edge, the set wins.
REQ-023 Reads of index 0 return 0 regardless of any write.
REQ-024 ex_valid falls after a transfer with no simultaneous accept. Output payload is held stable while ex_valid && !ex_ready.
REQ-025 With flush=1, ex_valid is 0 on the next cycle. If the squashed instruction had ex_rd_we && ex_rd!=0, its busy bit is cleared. No accept occurs that cycle.
REQ-026 flush with ex_valid=0 has no effect other than blocking the accept.
REQ-027 Operands are read combinationally in the accept cycle and registered; there is no read of stale output after accept.

Reset
REQ-028 While rst=1: ex_valid=0, busy_mask=0, all registers=0, ex_* payload outputs=0, and id_ready=0.
REQ-029 rst asserted mid-operation discards any held instruction and all pending busy bits on that edge; wb writes in that cycle are ignored.

Configuration
REQ-030 With macro OPERAND_BYPASS_EN defined:
  - a same-cycle WB write to rs1/rs2 forwards wb_data into the accepted operand;
  - busy[wb_rd] is treated as clear for the hazard check in that cycle.
REQ-031 Without OPERAND_BYPASS_EN: hazard uses the registered busy bits only, so the dependent instruction is accepted one cycle after the WB write and reads the stored value.

Structure
REQ-032 XLEN, NREGS and REG_ADDR_W (5) shall live in config_pkg. An operand bundle struct (rs1_data, rs2_data, rd, rd_we, tag) shall live in instruction_pkg.
REQ-033 The storage shall be one sub-module, regfile_2r1w: two asynchronous read ports, one synchronous write port, x0 forced to zero. Scoreboard and handshake logic stay in operand_read_stage.

Verification
REQ-034 Write x5=0x1234 via WB, then issue rs1=5, rs2=0 -> ex_rs1_data=0x1234, ex_rs2_data=0 one cycle after accept.
REQ-035 Issue rd=7 with rd_we=1, then issue rs1=7 -> id_ready=0 and busy_mask[7]=1 until the WB write to x7=0xAA. The dependent instruction is then accepted with 0xAA: same cycle with bypass, one cycle later without.
REQ-036 Hold ex_ready=0 for 3 cycles with ex_valid=1 -> id_ready=0 and ex_* stable; after ex_ready=1, the next instruction is accepted in that cycle.
REQ-037 WB writes x0=0xFFFF, then read x0 -> 0; issue with rd=0, rd_we=1 -> busy_mask stays 0.
REQ-038 Issue rd=9, then flush while held -> ex_valid=0 next cycle, busy_mask[9]=0, and a later rs1=9 issue is not stalled.
REQ-039 Assert rst with busy_mask=0x0000_0300 and ex_valid=1 -> next cycle busy_mask=0, ex_valid=0, and a read of x8 returns 0.
